// File: rtl/apb_pkg.sv
// Shared APB slave definitions: FSM state encoding, default widths and wait-state limit.
// Out-of-range error reporting is controlled by the APB_SLV_SLVERR_EN macro in apb_slave_regs.
package apb_pkg;

  localparam int APB_ADDR_W   = 4;
  localparam int APB_DATA_W   = 8;
  localparam int APB_MAX_WAIT = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/apb_regfile.sv
// DEPTH x DATA_W register storage with async reset, one qualified write port
// and a combinational read port that returns 0 for unimplemented addresses.
module apb_regfile
  import apb_pkg::*;
#(
  parameter int ADDR_W = APB_ADDR_W,
  parameter int DATA_W = APB_DATA_W,
  parameter int DEPTH  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  // DEPTH may equal 2**ADDR_W, so the bound needs one extra bit.
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              w_ok;
  logic              r_ok;

  assign w_ok = ({1'b0, waddr} < DEPTH_C);
  assign r_ok = ({1'b0, raddr} < DEPTH_C);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we && w_ok) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = r_ok ? mem[raddr] : '0;

endmodule

// File: rtl/apb_slave_regs.sv
// APB slave with programmable wait states in front of an internal register file.
// Define APB_SLV_SLVERR_EN to report out-of-range accesses on pslverr (tied to 0 otherwise).
module apb_slave_regs
  import apb_pkg::*;
#(
  parameter int ADDR_W      = APB_ADDR_W,
  parameter int DATA_W      = APB_DATA_W,
  parameter int DEPTH       = 12,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr
);

  // Handshake: a transfer is a setup cycle (psel=1, penable=0) followed by access
  // cycles (psel=1, penable=1); it completes on the edge where psel, penable and
  // pready are all 1. Dropping psel before that edge aborts the transfer.

`ifdef APB_SLV_SLVERR_EN
  localparam logic SLVERR_EN = 1'b1;
`else
  localparam logic SLVERR_EN = 1'b0;
`endif

  localparam logic [ADDR_W:0] DEPTH_C   = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0]      WAIT_LOAD = 4'(WAIT_CYCLES);

  state_t            state, state_d;
  logic [3:0]        cnt, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] prdata_d;
  logic              pready_d;
  logic              pslverr_d;
  logic              we;
  logic              setup;
  logic              setup_err;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;

  assign setup     = psel && !penable;
  assign setup_err = ({1'b0, paddr} >= DEPTH_C);
  // Zero-wait transfers read at the setup edge, before the address is captured.
  assign rd_addr   = setup ? paddr : addr_q;

  apb_regfile #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_regfile (
    .clk   (pclk),
    .rst   (preset),
    .we    (we),
    .waddr (addr_q),
    .wdata (wdata_q),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    addr_d    = addr_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    err_d     = err_q;
    prdata_d  = prdata;
    pready_d  = pready;
    pslverr_d = pslverr;
    we        = 1'b0;

    if (setup) begin
      addr_d    = paddr;
      write_d   = pwrite;
      wdata_d   = pwdata;
      err_d     = setup_err;
      prdata_d  = '0;
      pready_d  = 1'b0;
      pslverr_d = 1'b0;
      if (WAIT_CYCLES == 0) begin
        state_d   = DONE;
        cnt_d     = '0;
        pready_d  = 1'b1;
        pslverr_d = SLVERR_EN && setup_err;
        prdata_d  = (!pwrite && !setup_err) ? rd_data : '0;
      end else begin
        state_d = WAIT;
        cnt_d   = WAIT_LOAD;
      end
    end else begin
      case (state)
        IDLE: begin
        end
        WAIT: begin
          if (!psel) begin
            state_d   = IDLE;
            cnt_d     = '0;
            prdata_d  = '0;
            pready_d  = 1'b0;
            pslverr_d = 1'b0;
          end else if (penable && cnt != 4'd0) begin
            cnt_d = cnt - 4'd1;
            if (cnt == 4'd1) begin
              state_d   = DONE;
              pready_d  = 1'b1;
              pslverr_d = SLVERR_EN && err_q;
              prdata_d  = (!write_q && !err_q) ? rd_data : '0;
            end
          end
        end
        DONE: begin
          if (psel && penable) begin
            we = write_q && !err_q;
          end
          if (!psel || penable) begin
            state_d   = IDLE;
            cnt_d     = '0;
            prdata_d  = '0;
            pready_d  = 1'b0;
            pslverr_d = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      prdata  <= '0;
      pready  <= 1'b0;
      pslverr <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      prdata  <= prdata_d;
      pready  <= pready_d;
      pslverr <= pslverr_d;
    end
  end

endmodule

// File: tb/tb_apb_slave_regs.sv
// Bench for apb_slave_regs: three instances (WAIT_CYCLES 1, 0, 3) on one clock,
// a register model, and an expected-response queue checked when pready is seen.
module tb_apb_slave_regs;

  localparam int DEPTH = 12;
  localparam int NI    = 3;
  localparam int WC [NI] = '{1, 0, 3};

  logic       pclk = 1'b0;
  logic       preset;
  logic       psel_v    [NI];
  logic       penable_v [NI];
  logic       pwrite_v  [NI];
  logic [3:0] paddr_v   [NI];
  logic [7:0] pwdata_v  [NI];
  logic [7:0] prdata_v  [NI];
  logic       pready_v  [NI];
  logic       pslverr_v [NI];

  int n_cmp = 0;
  int n_err = 0;

  // Entry: {is_read, pslverr, prdata}
  logic [9:0] exp_q [$];
  logic [7:0] model_mem [NI][16];

  // Clock / reset
  always #5 pclk = ~pclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  for (genvar g = 0; g < NI; g++) begin : g_dut
    apb_slave_regs #(
      .ADDR_W      (4),
      .DATA_W      (8),
      .DEPTH       (DEPTH),
      .WAIT_CYCLES (WC[g])
    ) dut (
      .pclk    (pclk),
      .preset  (preset),
      .psel    (psel_v[g]),
      .penable (penable_v[g]),
      .pwrite  (pwrite_v[g]),
      .paddr   (paddr_v[g]),
      .pwdata  (pwdata_v[g]),
      .prdata  (prdata_v[g]),
      .pready  (pready_v[g]),
      .pslverr (pslverr_v[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic exp_err(input logic [3:0] a);
`ifdef APB_SLV_SLVERR_EN
    return (a >= DEPTH);
`else
    return 1'b0;
`endif
  endfunction

  // Driver: one complete transfer; keep=1 leaves psel high for a back-to-back follow-on.
  task automatic xfer(input int i, input logic wr, input logic [3:0] a,
                      input logic [7:0] d, input logic keep);
    logic [9:0] e;
    logic       oor;
    logic       b2b;
    logic       seen;
    int         cyc;
    oor = (a >= DEPTH);
    exp_q.push_back({~wr, exp_err(a), (wr || oor) ? 8'h00 : model_mem[i][a]});
    @(negedge pclk);
    b2b          = psel_v[i];
    psel_v[i]    = 1'b1;
    penable_v[i] = 1'b0;
    pwrite_v[i]  = wr;
    paddr_v[i]   = a;
    pwdata_v[i]  = d;
    if (b2b) chk($sformatf("pready_drop_b2b_i%0d", i), pready_v[i], 0);
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < 40) begin
      @(negedge pclk);
      penable_v[i] = 1'b1;
      cyc++;
      seen = pready_v[i];
    end
    if (!seen) begin
      chk($sformatf("pready_timeout_i%0d", i), pready_v[i], 1);
      void'(exp_q.pop_front());
    end else begin
      chk($sformatf("latency_i%0d", i), cyc, WC[i] + 1);
      e = exp_q.pop_front();
      chk($sformatf("pslverr_i%0d_a%0d", i, a), pslverr_v[i], e[8]);
      if (e[9]) chk($sformatf("prdata_i%0d_a%0d", i, a), prdata_v[i], e[7:0]);
      if (wr && !oor) model_mem[i][a] = d;
    end
    if (!keep) begin
      @(negedge pclk);
      psel_v[i]    = 1'b0;
      penable_v[i] = 1'b0;
      chk($sformatf("pready_drop_i%0d", i), pready_v[i], 0);
    end
  endtask

  // Write that is abandoned by dropping psel in its second access cycle.
  task automatic abort_write(input int i, input logic [3:0] a, input logic [7:0] d);
    logic seen;
    @(negedge pclk);
    psel_v[i]    = 1'b1;
    penable_v[i] = 1'b0;
    pwrite_v[i]  = 1'b1;
    paddr_v[i]   = a;
    pwdata_v[i]  = d;
    @(negedge pclk);
    penable_v[i] = 1'b1;
    seen = pready_v[i];
    @(negedge pclk);
    seen = seen | pready_v[i];
    psel_v[i]    = 1'b0;
    penable_v[i] = 1'b0;
    repeat (6) begin
      @(negedge pclk);
      seen = seen | pready_v[i];
    end
    chk($sformatf("abort_no_pready_i%0d", i), seen, 0);
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      psel_v[i]    = 1'b0;
      penable_v[i] = 1'b0;
      pwrite_v[i]  = 1'b0;
      paddr_v[i]   = '0;
      pwdata_v[i]  = '0;
      for (int j = 0; j < 16; j++) model_mem[i][j] = 8'h00;
    end
    preset = 1'b1;
    repeat (3) @(negedge pclk);
    preset = 1'b0;
    @(negedge pclk);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rst_prdata_i%0d", i), prdata_v[i], 0);
      chk($sformatf("rst_pready_i%0d", i), pready_v[i], 0);
      chk($sformatf("rst_pslverr_i%0d", i), pslverr_v[i], 0);
    end
    for (int i = 0; i < NI; i++) xfer(i, 1'b0, 4'd3, 8'h00, 1'b0);

    // One wait state: write then read back
    xfer(0, 1'b1, 4'd2, 8'hA5, 1'b0);
    xfer(0, 1'b0, 4'd2, 8'h00, 1'b0);

    // Zero wait states, psel held across back-to-back transfers
    xfer(1, 1'b1, 4'd0, 8'h11, 1'b1);
    xfer(1, 1'b1, 4'd1, 8'h22, 1'b1);
    xfer(1, 1'b0, 4'd0, 8'h00, 1'b1);
    xfer(1, 1'b0, 4'd1, 8'h00, 1'b0);

    // Out of range
    xfer(0, 1'b1, 4'd13, 8'h77, 1'b0);
    xfer(0, 1'b0, 4'd13, 8'h00, 1'b0);
    xfer(0, 1'b1, 4'd11, 8'hC3, 1'b0);
    xfer(0, 1'b0, 4'd11, 8'h00, 1'b0);

    // Abort
    abort_write(2, 4'd4, 8'h5A);
    xfer(2, 1'b0, 4'd4, 8'h00, 1'b0);

    // Random bursts per instance
    for (int i = 0; i < NI; i++) begin
      for (int n = 0; n < 10; n++) begin
        xfer(i, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
             8'($urandom_range(0, 255)), (n == 9) ? 1'b0 : 1'($urandom_range(0, 1)));
      end
    end

    // Reset mid-transfer: instance 1 showing pready, instance 2 waiting on a write
    xfer(1, 1'b1, 4'd0, 8'h96, 1'b0);
    @(negedge pclk);
    psel_v[1] = 1'b1; penable_v[1] = 1'b0; pwrite_v[1] = 1'b0; paddr_v[1] = 4'd0;
    psel_v[2] = 1'b1; penable_v[2] = 1'b0; pwrite_v[2] = 1'b1; paddr_v[2] = 4'd5;
    pwdata_v[2] = 8'h3C;
    @(negedge pclk);
    penable_v[1] = 1'b1;
    penable_v[2] = 1'b1;
    chk("pre_rst_pready_i1", pready_v[1], 1);
    chk("pre_rst_prdata_i1", prdata_v[1], model_mem[1][0]);
    #1 preset = 1'b1;
    #1;
    chk("async_rst_pready_i1", pready_v[1], 0);
    chk("async_rst_prdata_i1", prdata_v[1], 0);
    chk("async_rst_pready_i2", pready_v[2], 0);
    chk("async_rst_pslverr_i2", pslverr_v[2], 0);
    for (int i = 0; i < NI; i++) begin
      psel_v[i]    = 1'b0;
      penable_v[i] = 1'b0;
      for (int j = 0; j < 16; j++) model_mem[i][j] = 8'h00;
    end
    @(negedge pclk);
    preset = 1'b0;
    xfer(2, 1'b0, 4'd5, 8'h00, 1'b0);
    xfer(1, 1'b0, 4'd0, 8'h00, 1'b0);
    xfer(0, 1'b0, 4'd2, 8'h00, 1'b0);

    chk("exp_q_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
